// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg
//   Shared definitions for the RV32I store buffer slice: store funct3
//   encodings, drain FSM state encoding and the queued-entry record.
package store_buffer_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_BUSY = 2'b11
  } drain_state_e;

  // One formatted store: word address, byte strobe, lane-aligned data.
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } st_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// store_buffer_if
//   Bundles the store-request handshake, the data-memory write port and the
//   buffer status lines.
//   slave  : the store buffer (consumes ST_*, LOADING; drives the rest)
//   master : the surrounding pipeline / memory (drives ST_*, LOADING)
//   Signals:
//     ST_VALID/ST_READY/ST_ADDR/ST_DATA/ST_FUNCT3 - store request handshake
//     WRADDR/WREN/WRSTRB/WRDATA                    - data-memory write port
//     LOADING                                      - data memory busy
//     EMPTY/COUNT/ERR                              - status
interface store_buffer_if #(
  parameter int DEPTH_LOG2 = 2
);
  logic                  ST_VALID;
  logic                  ST_READY;
  logic [31:0]           ST_ADDR;
  logic [31:0]           ST_DATA;
  logic [2:0]            ST_FUNCT3;
  logic [31:0]           WRADDR;
  logic                  WREN;
  logic [3:0]            WRSTRB;
  logic [31:0]           WRDATA;
  logic                  LOADING;
  logic                  EMPTY;
  logic [DEPTH_LOG2:0]   COUNT;
  logic                  ERR;

  modport slave (
    input  ST_VALID, ST_ADDR, ST_DATA, ST_FUNCT3, LOADING,
    output ST_READY, WRADDR, WREN, WRSTRB, WRDATA, EMPTY, COUNT, ERR
  );

  modport master (
    output ST_VALID, ST_ADDR, ST_DATA, ST_FUNCT3, LOADING,
    input  ST_READY, WRADDR, WREN, WRSTRB, WRDATA, EMPTY, COUNT, ERR
  );
endinterface

// File: rtl/store_buffer_fmt.sv
// store_fmt
//   Combinational store formatter. Turns a byte address, raw rs2 value and
//   funct3 into a word-aligned address, byte strobe and lane-replicated data,
//   and flags illegal funct3 or a misaligned SH/SW.
//   Ports:
//     addr    in  32  byte address
//     data    in  32  raw rs2 value
//     funct3  in  3   store width
//     entry   out     formatted entry (addr/strb/data)
//     illegal out 1   request must be dropped
module store_fmt
  import store_buffer_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [31:0] data,
  input  logic [2:0]  funct3,
  output st_entry_t   entry,
  output logic        illegal
);

  always_comb begin
    entry.addr = {addr[31:2], 2'b00};
    entry.strb = 4'b0000;
    entry.data = 32'h0;
    illegal    = 1'b0;
    case (funct3)
      F3_SB: begin
        entry.strb = 4'b0001 << addr[1:0];
        entry.data = {4{data[7:0]}};
      end
      F3_SH: begin
        illegal    = addr[0];
        entry.strb = 4'b0011 << addr[1:0];
        entry.data = {2{data[15:0]}};
      end
      F3_SW: begin
        illegal    = |addr[1:0];
        entry.strb = 4'b1111;
        entry.data = data;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// store_buffer
//   RV32I store queue in front of the data-memory write port. Accepted
//   stores are formatted, queued in a DEPTH-entry FIFO and drained one at a
//   time: a one-cycle WREN pulse, then the write fields held until LOADING
//   drops, then the head is retired.
//   Optional build macro: STORE_BUF_COALESCE_EN - a legal store to the same
//   word as the tail entry merges into it instead of allocating, unless the
//   tail is the head currently being written.
//   Ports:
//     CLK, RST  clock, asynchronous active-high reset
//     sb        store_buffer_if.slave (request handshake, write port, status)
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2
) (
  input logic          CLK,
  input logic          RST,
  store_buffer_if.slave sb
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] CNT_ZERO  = '0;

  st_entry_t             fifo_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  drain_state_e          state;

  logic        wren_q;
  logic [31:0] wraddr_q;
  logic [3:0]  wrstrb_q;
  logic [31:0] wrdata_q;
  logic        err_p1;

  st_entry_t   fmt_p0;
  logic        illegal_p0;
  st_entry_t   head;
  logic        full;
  logic        ready;
  logic        issue;
  logic        pop;
  logic        mergeable;
  logic        hs;
  logic        push;

  // p0: format the incoming request
  store_fmt u_fmt (
    .addr    (sb.ST_ADDR),
    .data    (sb.ST_DATA),
    .funct3  (sb.ST_FUNCT3),
    .entry   (fmt_p0),
    .illegal (illegal_p0)
  );

  assign head  = fifo_q[rd_ptr];
  assign full  = (count == DEPTH_CNT);
  // In S_IDLE the head is never issued yet, so any queued entry may go.
  assign issue = (state == S_IDLE) && (count != CNT_ZERO) && !sb.LOADING;
  assign pop   = (state == S_BUSY) && !sb.LOADING;

`ifdef STORE_BUF_COALESCE_EN
  localparam logic [DEPTH_LOG2:0] CNT_ONE = (DEPTH_LOG2 + 1)'(1);

  logic [DEPTH_LOG2-1:0] tail_ptr;
  logic                  merge;

  function automatic st_entry_t merge_entry(input st_entry_t old_e,
                                            input st_entry_t new_e);
    st_entry_t m;
    m = old_e;
    for (int b = 0; b < 4; b++) begin
      if (new_e.strb[b]) m.data[b*8 +: 8] = new_e.data[b*8 +: 8];
    end
    m.strb = old_e.strb | new_e.strb;
    return m;
  endfunction

  assign tail_ptr  = wr_ptr - 1'b1;
  // A lone entry that is being issued this edge or is already on the bus
  // must not change under the registered write fields.
  assign mergeable = !illegal_p0 && (count != CNT_ZERO) &&
                     (fifo_q[tail_ptr].addr == fmt_p0.addr) &&
                     !((count == CNT_ONE) && ((state != S_IDLE) || issue));
  assign merge     = hs && mergeable;
`else
  assign mergeable = 1'b0;
`endif

  assign ready = !full || mergeable;
  assign hs    = sb.ST_VALID && ready;
  assign push  = hs && !illegal_p0 && !mergeable;

  // p1: FIFO pointers/occupancy and the error pulse
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_p1 <= 1'b0;
    end else begin
      err_p1 <= hs && illegal_p0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_q[wr_ptr] <= fmt_p0;
    end
`ifdef STORE_BUF_COALESCE_EN
    else if (merge) begin
      fifo_q[tail_ptr] <= merge_entry(fifo_q[tail_ptr], fmt_p0);
    end
`endif
  end

  // drain: registered write port, fields held from issue until retire
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      wren_q   <= 1'b0;
      wraddr_q <= 32'h0;
      wrstrb_q <= 4'b0000;
      wrdata_q <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          wren_q <= 1'b0;
          if (issue) begin
            wraddr_q <= head.addr;
            wrstrb_q <= head.strb;
            wrdata_q <= head.data;
            wren_q   <= 1'b1;
            state    <= S_REQ;
          end
        end
        S_REQ: begin
          wren_q <= 1'b0;
          state  <= S_BUSY;
        end
        S_BUSY: begin
          wren_q <= 1'b0;
          if (!sb.LOADING) state <= S_IDLE;
        end
        default: begin
          wren_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign sb.ST_READY = ready;
  assign sb.WREN     = wren_q;
  assign sb.WRADDR   = wraddr_q;
  assign sb.WRSTRB   = wrstrb_q;
  assign sb.WRDATA   = wrdata_q;
  assign sb.ERR      = err_p1;
  assign sb.COUNT    = count;
  assign sb.EMPTY    = (count == CNT_ZERO) && (state == S_IDLE);

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer
//   Self-checking bench for store_buffer: directed scenarios with literal
//   expectations, then randomized traffic checked cycle by cycle against a
//   queue-based reference model. A simple data-memory model drives LOADING.
module tb_store_buffer;
  import store_buffer_pkg::*;

  typedef struct packed {
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
  } ent_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  store_buffer_if #(.DEPTH_LOG2(2)) bus ();

  store_buffer #(.DEPTH_LOG2(2)) dut (
    .CLK (CLK),
    .RST (RST),
    .sb  (bus)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // data memory: LOADING high in the WREN cycle and mem_lat-1 cycles after
  logic force_busy = 1'b0;
  int   mem_lat    = 3;
  int   mem_left   = 0;
  assign bus.LOADING = force_busy | bus.WREN | (mem_left != 0);

  always @(posedge CLK or posedge RST) begin
    if (RST)                 mem_left <= 0;
    else if (bus.WREN)       mem_left <= mem_lat - 1;
    else if (mem_left != 0)  mem_left <= mem_left - 1;
  end

  initial forever begin
    @(posedge CLK);
    cyc = cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Store semantics from the ISA: a store of sz bytes at byte offset off
  // touches lanes off..off+sz-1; the data bus carries the value replicated.
  function automatic void fmt_ref(input logic [31:0] a, input logic [31:0] d,
                                  input logic [2:0] f, output ent_t e, output bit ok);
    int sz;
    int off;
    sz  = (f == 3'd0) ? 1 : (f == 3'd1) ? 2 : (f == 3'd2) ? 4 : 0;
    off = int'(a[1:0]);
    ok  = (sz != 0) && ((off % ((sz == 0) ? 1 : sz)) == 0);
    e.a = {a[31:2], 2'b00};
    e.s = 4'b0000;
    e.d = 32'h0;
    if (ok) begin
      for (int l = 0; l < 4; l++) begin
        e.d[l*8 +: 8] = d[(l % sz)*8 +: 8];
        if (l >= off && l < off + sz) e.s[l] = 1'b1;
      end
    end
  endfunction

  ent_t mq[$];          // accepted, not yet retired (head may be on the bus)
  int   phase = 0;      // 0: no write outstanding, 1: pulse cycle, 2: waiting on memory
  ent_t cur   = '0;     // fields currently presented on the write port
  bit   err_e = 1'b0;

`ifdef STORE_BUF_COALESCE_EN
  function automatic bit merge_ok(input ent_t e, input bit ok, input bit ld);
    int n;
    bit head_busy;
    n = mq.size();
    head_busy = (phase != 0) || !ld;
    return ok && (n > 0) && (mq[n-1].a == e.a) && !((n == 1) && head_busy);
  endfunction
`endif

  task automatic model_step();
    ent_t e;
    ent_t t;
    bit   ok;
    bit   ld;
    bit   mrg;
    bit   hs;
    bit   issue;
    bit   pop;
    int   n;
    ld = bus.LOADING;
    n  = mq.size();
    fmt_ref(bus.ST_ADDR, bus.ST_DATA, bus.ST_FUNCT3, e, ok);
    mrg = 1'b0;
`ifdef STORE_BUF_COALESCE_EN
    mrg = merge_ok(e, ok, ld);
`endif
    hs    = bus.ST_VALID && ((n < 4) || mrg);
    issue = (phase == 0) && (n > 0) && !ld;
    pop   = (phase == 2) && !ld;
    err_e = hs && !ok;
    if (phase == 1) phase = 2;
    else if (pop) begin
      void'(mq.pop_front());
      phase = 0;
    end else if (issue) begin
      cur   = mq[0];
      phase = 1;
    end
    if (hs && ok) begin
      if (mrg) begin
        t = mq[$];
        for (int l = 0; l < 4; l++) if (e.s[l]) t.d[l*8 +: 8] = e.d[l*8 +: 8];
        t.s   = t.s | e.s;
        mq[$] = t;
      end else begin
        mq.push_back(e);
      end
    end
  endtask

  initial forever begin
    @(posedge CLK or posedge RST);
    if (RST) begin
      mq.delete();
      phase = 0;
      cur   = '0;
      err_e = 1'b0;
    end else begin
      model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 1'b0;
  initial forever begin
    bit mrg;
    bit ready_e;
`ifdef STORE_BUF_COALESCE_EN
    ent_t e;
    bit   ok;
`endif
    @(negedge CLK);
    if (cmp_en) begin
      mrg = 1'b0;
`ifdef STORE_BUF_COALESCE_EN
      fmt_ref(bus.ST_ADDR, bus.ST_DATA, bus.ST_FUNCT3, e, ok);
      mrg = merge_ok(e, ok, bus.LOADING);
`endif
      ready_e = (mq.size() < 4) || mrg;
      chk("COUNT",    32'(bus.COUNT),    32'(mq.size()));
      chk("EMPTY",    32'(bus.EMPTY),    32'((mq.size() == 0) && (phase == 0)));
      chk("ERR",      32'(bus.ERR),      32'(err_e));
      chk("WREN",     32'(bus.WREN),     32'(phase == 1));
      chk("ST_READY", 32'(bus.ST_READY), 32'(ready_e));
      chk("WRADDR",   bus.WRADDR,        cur.a);
      chk("WRSTRB",   32'(bus.WRSTRB),   32'(cur.s));
      chk("WRDATA",   bus.WRDATA,        cur.d);
    end
  end

  // ---------------- observation log ----------------
  ent_t wlog[$];
  int   wren_cnt      = 0;
  int   err_cnt       = 0;
  int   max_cnt       = 0;
  int   last_wren_cyc = 0;
  int   last_hs_cyc   = 0;

  initial forever begin
    @(negedge CLK);
    if (bus.WREN === 1'b1) begin
      wlog.push_back({bus.WRADDR, bus.WRSTRB, bus.WRDATA});
      wren_cnt++;
      last_wren_cyc = cyc;
    end
    if (bus.ERR === 1'b1) err_cnt++;
    if (int'(bus.COUNT) > max_cnt) max_cnt = int'(bus.COUNT);
  end

  task automatic chk_wr(input string nm, input int idx, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d);
    ent_t w;
    w = '0;
    if (idx < wlog.size()) w = wlog[idx];
    chk({nm, "_addr"}, w.a, a);
    chk({nm, "_strb"}, 32'(w.s), 32'(s));
    chk({nm, "_data"}, w.d, d);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    bit done;
    bit r;
    int c;
    done = 1'b0;
    @(posedge CLK);
    #2;
    bus.ST_VALID  = 1'b1;
    bus.ST_ADDR   = a;
    bus.ST_DATA   = d;
    bus.ST_FUNCT3 = f;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge CLK);
      r = bus.ST_READY;
      c = cyc;
      @(posedge CLK);
      if (r) begin
        done = 1'b1;
        last_hs_cyc = c;
      end
    end
    #2;
    bus.ST_VALID = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL push_timeout actual=not_accepted required=accepted addr=0x%0h", a);
    end
  endtask

  task automatic wait_empty(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge CLK);
      if (bus.EMPTY === 1'b1 && bus.LOADING === 1'b0) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_drain actual=busy required=empty", nm);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "simulation timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    int base;
    int snap;
    int err0;
    logic [31:0] addr;
    logic [2:0]  f3;
    int          r;

    bus.ST_VALID  = 1'b0;
    bus.ST_ADDR   = 32'h0;
    bus.ST_DATA   = 32'h0;
    bus.ST_FUNCT3 = F3_SW;

    // reset state
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_count",  32'(bus.COUNT),  32'd0);
    chk("rst_empty",  32'(bus.EMPTY),  32'd1);
    chk("rst_wren",   32'(bus.WREN),   32'd0);
    chk("rst_wraddr", bus.WRADDR,      32'h0);
    chk("rst_err",    32'(bus.ERR),    32'd0);
    cmp_en = 1'b1;
    @(posedge CLK);
    #2;
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_ready", 32'(bus.ST_READY), 32'd1);

    // SB to byte 3
    mem_lat = 3;
    base = wlog.size();
    push(32'h0000_1003, 32'h0000_00AB, F3_SB);
    wait_empty("sb");
    chk("sb_writes", 32'(wlog.size() - base), 32'd1);
    chk_wr("sb", base, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB);
    chk("sb_latency", 32'(last_wren_cyc - last_hs_cyc), 32'd2);

    // SH then SW, drained in order
    base = wlog.size();
    push(32'h0000_2002, 32'h0000_1234, F3_SH);
    push(32'h0000_2004, 32'hDEAD_BEEF, F3_SW);
    wait_empty("sh_sw");
    chk_wr("sh", base,     32'h0000_2000, 4'b1100, 32'h1234_1234);
    chk_wr("sw", base + 1, 32'h0000_2004, 4'b1111, 32'hDEAD_BEEF);

    // misaligned SW and illegal funct3
    base = wlog.size();
    err0 = err_cnt;
    push(32'h0000_3001, 32'h5555_5555, F3_SW);
    push(32'h0000_3000, 32'h6666_6666, 3'b011);
    repeat (4) @(negedge CLK);
    chk("err_pulses", 32'(err_cnt - err0), 32'd2);
    chk("err_nowrite", 32'(wlog.size() - base), 32'd0);
    chk("err_count", 32'(bus.COUNT), 32'd0);

    // fill while memory is busy; fifth request stalls
    base = wlog.size();
    max_cnt = 0;
    @(posedge CLK);
    #2;
    force_busy = 1'b1;
    for (int i = 0; i < 4; i++) push(32'h0000_5000 + 32'(4 * i), 32'(i), F3_SW);
    fork
      push(32'h0000_5010, 32'd4, F3_SW);
      begin
        repeat (6) @(negedge CLK);
        chk("full_count", 32'(bus.COUNT),    32'd4);
        chk("full_ready", 32'(bus.ST_READY), 32'd0);
        @(posedge CLK);
        #2;
        force_busy = 1'b0;
      end
    join
    wait_empty("full");
    chk("full_peak", 32'(max_cnt), 32'd4);
    for (int i = 0; i < 5; i++)
      chk_wr("full_order", base + i, 32'h0000_5000 + 32'(4 * i), 4'b1111, 32'(i));

    // asynchronous reset while a write is outstanding
    mem_lat = 20;
    push(32'h0000_6000, 32'h1, F3_SW);
    push(32'h0000_6004, 32'h2, F3_SW);
    push(32'h0000_6008, 32'h3, F3_SW);
    repeat (2) @(negedge CLK);
    chk("pre_rst_count", 32'(bus.COUNT), 32'd3);
    chk("pre_rst_empty", 32'(bus.EMPTY), 32'd0);
    @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    chk("arst_wren",  32'(bus.WREN),  32'd0);
    chk("arst_count", 32'(bus.COUNT), 32'd0);
    chk("arst_empty", 32'(bus.EMPTY), 32'd1);
    repeat (2) @(posedge CLK);
    #2;
    RST = 1'b0;
    snap = wren_cnt;
    repeat (30) @(negedge CLK);
    chk("arst_nowren", 32'(wren_cnt - snap), 32'd0);
    mem_lat = 2;

`ifdef STORE_BUF_COALESCE_EN
    // two bytes of one word merge into a single entry
    base = wlog.size();
    @(posedge CLK);
    #2;
    force_busy = 1'b1;
    push(32'h0000_4000, 32'h11, F3_SB);
    push(32'h0000_4001, 32'h22, F3_SB);
    @(negedge CLK);
    chk("merge_count", 32'(bus.COUNT), 32'd1);
    @(posedge CLK);
    #2;
    force_busy = 1'b0;
    wait_empty("merge");
    chk("merge_writes", 32'(wlog.size() - base), 32'd1);
    chk_wr("merge", base, 32'h0000_4000, 4'b0011, 32'h1111_2211);
`endif

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      @(posedge CLK);
      #2;
      r = $urandom_range(0, 99);
      f3 = (r < 30) ? F3_SB : (r < 55) ? F3_SH : (r < 90) ? F3_SW : 3'($urandom_range(3, 7));
      addr = 32'h0000_8000 + 32'(4 * $urandom_range(0, 2)) + 32'($urandom_range(0, 3));
      bus.ST_VALID  = ($urandom_range(0, 99) < 55);
      bus.ST_ADDR   = addr;
      bus.ST_DATA   = $urandom;
      bus.ST_FUNCT3 = f3;
      if ($urandom_range(0, 99) < 8)  force_busy = ~force_busy;
      if ($urandom_range(0, 99) < 10) mem_lat = $urandom_range(1, 4);
    end
    @(posedge CLK);
    #2;
    bus.ST_VALID = 1'b0;
    force_busy   = 1'b0;
    wait_empty("random");
    chk("final_count", 32'(bus.COUNT), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
